// File: rtl/onewire_master_cycle.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : onewire_master_cycle                                         |
// | Description : 1-wire bus master cycle engine. Runs one reset/presence      |
// |               cycle or one bit time slot per accepted request, with        |
// |               normal or overdrive timing, and returns a one-clock response. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module onewire_master_cycle #(
  parameter int unsigned CDR_N = 50,
  parameter int unsigned CDR_O = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic req_vld,
  output logic req_rdy,
  input  logic req_rst,
  input  logic req_dat,
  input  logic req_ovd,
  output logic rsp_vld,
  output logic rsp_dat,
  output logic rsp_err,
  output logic owr_p,
  input  logic owr_i
);

  // Prescaler must hold values up to the larger of the two dividers.
  localparam int unsigned c_DIV_MAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
  localparam int unsigned c_PW      = $clog2(c_DIV_MAX + 1);

  // Slot timing in ticks: low time, sample point, end of cycle.
  localparam logic [9:0] c_W0_LOW  = 10'd60;
  localparam logic [9:0] c_W1_LOW  = 10'd6;
  localparam logic [9:0] c_BIT_SMP = 10'd12;
  localparam logic [9:0] c_BIT_END = 10'd64;
  localparam logic [9:0] c_RST_LOW = 10'd480;
  localparam logic [9:0] c_RST_SMP = 10'd550;
  localparam logic [9:0] c_RST_END = 10'd960;
  localparam logic [9:0] c_T_MAX   = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRV  = 2'd1,
    ST_RLS  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_cyc_rst;
  logic            r_cyc_dat;
  logic [c_PW-1:0] r_div;
  logic [c_PW-1:0] r_psc;
  logic [9:0]      r_t;
  logic            r_smp;
  logic            r_owr_p;
  logic            r_rsp_vld;
  logic            r_rsp_dat;
  logic            r_rsp_err;

  logic [9:0]      w_t_low;
  logic [9:0]      w_t_smp;
  logic [9:0]      w_t_end;
  logic            w_busy;
  logic            w_accept;
  logic            w_hit_low;
  logic            w_hit_smp;
  logic            w_hit_end;

  // Timing table for the cycle in flight and tick-boundary hit detection.
  // A boundary of T ticks is reached exactly when t==T with the prescaler at 0,
  // which happens once, on edge k+1+T*div.
  always_comb begin
    w_t_low = c_W1_LOW;
    w_t_smp = c_BIT_SMP;
    w_t_end = c_BIT_END;
    if (r_cyc_rst) begin
      w_t_low = c_RST_LOW;
      w_t_smp = c_RST_SMP;
      w_t_end = c_RST_END;
    end else if (!r_cyc_dat) begin
      w_t_low = c_W0_LOW;
    end
    w_busy    = (r_state != ST_IDLE);
    w_accept  = (r_state == ST_IDLE) && req_vld;
    w_hit_low = w_busy && (r_t == w_t_low) && (r_psc == '0);
    w_hit_smp = w_busy && (r_t == w_t_smp) && (r_psc == '0);
    w_hit_end = w_busy && (r_t == w_t_end) && (r_psc == '0);
  end

  // Next-state logic and idle handshake.
  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) w_state_nxt = ST_DRV;
      end
      ST_DRV: begin
        if (w_hit_end)      w_state_nxt = ST_IDLE;
        else if (w_hit_low) w_state_nxt = ST_RLS;
      end
      ST_RLS: begin
        if (w_hit_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Two-flop synchronizer for the asynchronous wire level; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= owr_i;
      r_sync2 <= r_sync1;
    end
  end

  // Request latch, prescaler and saturating tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_rst <= 1'b0;
      r_cyc_dat <= 1'b0;
      r_div     <= c_PW'(CDR_N);
      r_psc     <= '0;
      r_t       <= '0;
    end else if (w_accept) begin
      r_cyc_rst <= req_rst;
      r_cyc_dat <= req_dat;
      r_div     <= req_ovd ? c_PW'(CDR_O) : c_PW'(CDR_N);
      r_psc     <= '0;
      r_t       <= '0;
    end else if (w_busy) begin
      if (r_psc == r_div - c_PW'(1)) begin
        r_psc <= '0;
        if (r_t != c_T_MAX) r_t <= r_t + 10'd1;
      end else begin
        r_psc <= r_psc + c_PW'(1);
      end
    end
  end

  // Pull-down enable: asserted one edge after acceptance, for the whole drive phase.
  always_ff @(posedge clk) begin
    if (rst) r_owr_p <= 1'b0;
    else     r_owr_p <= (r_state == ST_DRV) && (w_state_nxt == ST_DRV);
  end

  // Capture the line at the sample point.
  always_ff @(posedge clk) begin
    if (rst)            r_smp <= 1'b0;
    else if (w_hit_smp) r_smp <= r_sync2;
  end

  // Response pulse at cycle end; data and error hold until the next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_vld <= w_hit_end;
      if (w_hit_end) begin
        r_rsp_dat <= r_cyc_rst ? ~r_smp : r_smp;
        r_rsp_err <= ~r_sync2;
      end
    end
  end

  assign owr_p   = r_owr_p;
  assign rsp_vld = r_rsp_vld;
  assign rsp_dat = r_rsp_dat;
  assign rsp_err = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_onewire_master_cycle.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_onewire_master_cycle                                      |
// | Description : Self-checking bench for onewire_master_cycle with a wired-AND |
// |               bus model and a tick-level slave behaviour model.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_onewire_master_cycle;

  localparam int CDR_N = 4;
  localparam int CDR_O = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_vld = 1'b0;
  logic req_rst = 1'b0;
  logic req_dat = 1'b0;
  logic req_ovd = 1'b0;
  logic req_rdy, rsp_vld, rsp_dat, rsp_err, owr_p, owr_i;

  int tests = 0;
  int fails = 0;

  // Slave model: pulls the wire low while elapsed clocks since edge k+1 fall in
  // [win_s, win_e) ticks; stuck models a shorted bus.
  int   elapsed = -1;
  int   win_s = 0;
  int   win_e = 0;
  int   cur_div = 1;
  logic stuck = 1'b0;

  always #5 clk = ~clk;

  assign owr_i = ~(owr_p | stuck |
                   ((elapsed >= 0) && (elapsed >= win_s * cur_div) && (elapsed < win_e * cur_div)));

  onewire_master_cycle #(.CDR_N(CDR_N), .CDR_O(CDR_O)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_vld(req_vld),
    .req_rdy(req_rdy),
    .req_rst(req_rst),
    .req_dat(req_dat),
    .req_ovd(req_ovd),
    .rsp_vld(rsp_vld),
    .rsp_dat(rsp_dat),
    .rsp_err(rsp_err),
    .owr_p  (owr_p),
    .owr_i  (owr_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wire level at a given tick of the cycle: low while the master drives, while
  // a slave holds it, or when shorted.
  function automatic bit line_hi(int tick, int tl, int ws, int we, bit stk);
    return !((tick < tl) || ((tick >= ws) && (tick < we)) || stk);
  endfunction

  function automatic bit far(int a, int b);
    return (a - b >= 4) || (b - a >= 4);
  endfunction

  task automatic run_cycle(input string name, input bit rc, input bit d, input bit ov,
                           input int ws, input int we, input bit stk, input bit poke,
                           input int abort_n);
    int div, tl, ts, te, rise_n, fall_n, end_n, limit;
    bit exp_dat, exp_err, rdy_at_end, dat_at_end, err_at_end;
    div = ov ? CDR_O : CDR_N;
    if (rc) begin tl = 480; ts = 550; te = 960; end
    else if (!d) begin tl = 60; ts = 12; te = 64; end
    else begin tl = 6; ts = 12; te = 64; end
    exp_dat = rc ? !line_hi(ts, tl, ws, we, stk) : line_hi(ts, tl, ws, we, stk);
    exp_err = !line_hi(te, tl, ws, we, stk);
    cur_div = div; win_s = ws; win_e = we; stuck = stk; elapsed = -1;
    rise_n = -1; fall_n = -1; end_n = -1;
    rdy_at_end = 1'b0; dat_at_end = 1'b0; err_at_end = 1'b0;
    limit = te * div + 20;

    @(negedge clk);
    check({name, "_rdy_before"}, 32'(req_rdy), 32'd1);
    req_vld = 1'b1; req_rst = rc; req_dat = d; req_ovd = ov;
    @(negedge clk);
    req_vld = 1'b0;
    req_rst = 1'($urandom_range(1)); req_dat = 1'($urandom_range(1)); req_ovd = 1'($urandom_range(1));

    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      elapsed = n - 1;
      if (owr_p === 1'b1 && rise_n < 0) rise_n = n;
      if (owr_p !== 1'b1 && rise_n > 0 && fall_n < 0) fall_n = n;
      if (rsp_vld === 1'b1 && end_n < 0) begin
        end_n = n; rdy_at_end = req_rdy; dat_at_end = rsp_dat; err_at_end = rsp_err;
      end
      if (poke) begin
        if (n == 20) begin req_vld = 1'b1; req_rst = 1'b1; end
        if (n == 30) check({name, "_busy_rdy"}, 32'(req_rdy), 32'd0);
        if (n == 40) req_vld = 1'b0;
      end
      if (abort_n > 0 && n == abort_n) rst = 1'b1;
      if (abort_n > 0 && n == abort_n + 1) begin
        check({name, "_abort_owr_p"}, 32'(owr_p), 32'd0);
        check({name, "_abort_rdy"}, 32'(req_rdy), 32'd1);
        rst = 1'b0;
      end
      if (end_n > 0) break;
    end

    if (abort_n > 0) begin
      check({name, "_no_rsp"}, 32'(end_n), 32'hFFFF_FFFF);
    end else begin
      check({name, "_owr_rise"}, 32'(rise_n), 32'd1);
      check({name, "_owr_fall"}, 32'(fall_n), 32'(1 + tl * div));
      check({name, "_rsp_at"}, 32'(end_n), 32'(1 + te * div));
      check({name, "_rdy_at_end"}, 32'(rdy_at_end), 32'd1);
      check({name, "_dat"}, 32'(dat_at_end), 32'(exp_dat));
      check({name, "_err"}, 32'(err_at_end), 32'(exp_err));
      @(posedge clk); #1;
      check({name, "_vld_pulse"}, 32'(rsp_vld), 32'd0);
      check({name, "_dat_hold"}, 32'(rsp_dat), 32'(exp_dat));
      check({name, "_idle_owr_p"}, 32'(owr_p), 32'd0);
    end

    stuck = 1'b0; elapsed = -1; win_s = 0; win_e = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("rst_rsp_dat", 32'(rsp_dat), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_owr_p",   32'(owr_p),   32'd0);
    rst = 1'b0;

    // name, reset cycle, data, overdrive, slave window, stuck, poke, abort edge
    run_cycle("w0",         1'b0, 1'b0, 1'b0,   0,   0, 1'b0, 1'b0, 0);
    run_cycle("rd_slave",   1'b0, 1'b1, 1'b0,   0,  30, 1'b0, 1'b0, 0);
    run_cycle("rd_silent",  1'b0, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0, 0);
    run_cycle("rst_pres",   1'b1, 1'b0, 1'b0, 510, 630, 1'b0, 1'b0, 0);
    run_cycle("rst_none",   1'b1, 1'b0, 1'b0,   0,   0, 1'b0, 1'b0, 0);
    run_cycle("ovd_rst",    1'b1, 1'b0, 1'b1,   0,   0, 1'b0, 1'b0, 0);
    run_cycle("ovd_w1",     1'b0, 1'b1, 1'b1,   0,   0, 1'b0, 1'b0, 0);
    run_cycle("stuck_w1",   1'b0, 1'b1, 1'b0,   0,   0, 1'b1, 1'b1, 0);
    run_cycle("abort_rst",  1'b1, 1'b0, 1'b0,   0,   0, 1'b0, 1'b0, 1 + 100 * CDR_N);
    run_cycle("post_abort", 1'b0, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      bit rc, d, ov, ok;
      int tsm, tend, ws, we, a, b;
      rc   = ($urandom_range(3) == 0);
      ov   = rc ? 1'b1 : 1'($urandom_range(1));
      d    = 1'($urandom_range(1));
      tsm  = rc ? 550 : 12;
      tend = rc ? 960 : 64;
      ws = 0; we = 0;
      if ($urandom_range(2) != 0) begin
        for (int tries = 0; tries < 50; tries++) begin
          a  = $urandom_range(tend - 1);
          b  = a + $urandom_range(tend - a + 10, 5);
          ok = far(a, tsm) && far(b, tsm) && far(a, tend) && far(b, tend);
          if (ok) begin ws = a; we = b; break; end
        end
      end
      run_cycle($sformatf("rnd%0d", i), rc, d, ov, ws, we, 1'b0, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
